// File: rtl/elastic_skid_fifo.sv
// elastic_skid_fifo
//   DEPTH-entry valid/ready elastic buffer with a registered up_ready, an
//   optional zero-latency bypass when empty (REG_OUT=0), an occupancy output
//   and a synchronous flush. It cuts ready paths between pipeline stages and
//   absorbs up to DEPTH beats of back-pressure slip without loss or duplication.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   flush      synchronous flush; empties the buffer
//   up_data    upstream data            up_valid / up_ready   upstream handshake
//   down_data  downstream data          down_valid / down_ready downstream handshake
//   level      entries currently stored (0..DEPTH), registered
module elastic_skid_fifo #(
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int REG_OUT = 0,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] up_data,
  input  logic          up_valid,
  output logic          up_ready,
  output logic [DW-1:0] down_data,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_up_ready;

  logic          w_empty;
  logic          w_up_fire;
  logic          w_down_fire;
  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_count_next;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_empty   = (r_count == '0);
    w_up_fire = up_valid & r_up_ready;

    // Bypass only while nothing is stored, so it can never overtake queued data.
    // Gating with r_up_ready keeps the bypass closed in the cycle after reset
    // release, when the upstream beat cannot yet be accepted.
    if (REG_OUT == 0 && w_empty) begin
      down_valid = up_valid & r_up_ready & ~flush;
      down_data  = up_data;
    end else begin
      down_valid = ~w_empty & ~flush;
      down_data  = r_mem[r_rd_ptr];
    end

    w_down_fire = down_valid & down_ready;

    if (REG_OUT == 0) begin
      // A bypassed beat taken downstream in the same cycle is never stored.
      w_push = w_up_fire & ~(w_empty & down_ready);
      w_pop  = w_down_fire & ~w_empty;
    end else begin
      w_push = w_up_fire;
      w_pop  = w_down_fire;
    end

    if (flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_up_ready <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      // Registered ready: one bubble after a pop on a full cycle is the price
      // of having no combinational path from down_ready to up_ready.
      r_up_ready <= (w_count_next < LW'(DEPTH));
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= up_data;
  end

  assign up_ready = r_up_ready;
  assign level    = r_count;

endmodule

// File: tb/tb_elastic_skid_fifo.sv
module tb_elastic_skid_fifo;

  // Instance 0: DEPTH=4 REG_OUT=0, instance 1: DEPTH=3 REG_OUT=0,
  // instance 2: DEPTH=5 REG_OUT=1.
  localparam int DEP [3] = '{4, 3, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic        fl   [3];
  logic [15:0] ud   [3];
  logic        uv   [3];
  logic        ur   [3];
  logic [15:0] dd   [3];
  logic        dv   [3];
  logic        dr   [3];
  logic [7:0]  lvx  [3];
  logic [2:0]  lv0;
  logic [1:0]  lv1;
  logic [2:0]  lv2;

  always #5 clk = ~clk;

  elastic_skid_fifo #(.DW(16), .DEPTH(4), .REG_OUT(0)) u0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .up_data(ud[0]), .up_valid(uv[0]),
    .up_ready(ur[0]), .down_data(dd[0]), .down_valid(dv[0]), .down_ready(dr[0]),
    .level(lv0));
  elastic_skid_fifo #(.DW(16), .DEPTH(3), .REG_OUT(0)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .up_data(ud[1]), .up_valid(uv[1]),
    .up_ready(ur[1]), .down_data(dd[1]), .down_valid(dv[1]), .down_ready(dr[1]),
    .level(lv1));
  elastic_skid_fifo #(.DW(16), .DEPTH(5), .REG_OUT(1)) u2 (
    .clk(clk), .rst(rst), .flush(fl[2]), .up_data(ud[2]), .up_valid(uv[2]),
    .up_ready(ur[2]), .down_data(dd[2]), .down_valid(dv[2]), .down_ready(dr[2]),
    .level(lv2));

  assign lvx[0] = 8'(lv0);
  assign lvx[1] = 8'(lv1);
  assign lvx[2] = 8'(lv2);

  int          total = 0;
  int          bad   = 0;
  logic [15:0] sbq   [3][$];
  logic        fired [3];
  logic        stall [3];
  logic [15:0] hold  [3];
  logic [15:0] seq   [3];
  logic        chk_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor, run once per cycle at the falling edge.
  task automatic sb();
    logic [15:0] e;
    for (int k = 0; k < 3; k++) begin
      fired[k] = 1'b0;
      if (rst) begin
        sbq[k].delete();
        stall[k] = 1'b0;
        continue;
      end
      chk($sformatf("level_vs_model[%0d]", k), 32'(lvx[k]), 32'(sbq[k].size()));
      if (chk_rdy)
        chk($sformatf("ready_vs_level[%0d]", k), 32'(ur[k]), 32'(lvx[k] < 8'(DEP[k])));
      fired[k] = uv[k] & ur[k];
      if (fl[k]) begin
        chk($sformatf("flush_dvalid[%0d]", k), 32'(dv[k]), 32'd0);
        sbq[k].delete();
        stall[k] = 1'b0;
        continue;
      end
      if (stall[k]) begin
        chk($sformatf("hold_valid[%0d]", k), 32'(dv[k]), 32'd1);
        chk($sformatf("hold_data[%0d]", k), 32'(dd[k]), 32'(hold[k]));
      end
      stall[k] = dv[k] & ~dr[k];
      hold[k]  = dd[k];
      if (fired[k]) sbq[k].push_back(ud[k]);
      if (dv[k] && dr[k]) begin
        chk($sformatf("sb_nonempty[%0d]", k), 32'(sbq[k].size() != 0), 32'd1);
        if (sbq[k].size() != 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("sb_data[%0d]", k), 32'(dd[k]), 32'(e));
        end
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    sb();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fl[k] = 1'b0; ud[k] = '0; uv[k] = 1'b0; dr[k] = 1'b0;
      stall[k] = 1'b0; hold[k] = '0; seq[k] = 16'd1; fired[k] = 1'b0;
    end

    // Reset state, with an upstream beat offered to check down_valid stays low.
    uv[0] = 1'b1; ud[0] = 16'h5555; dr[0] = 1'b1;
    #1;
    smp();
    chk("rst_up_ready", 32'(ur[0]), 32'd0);
    chk("rst_level",    32'(lv0),   32'd0);
    chk("rst_dvalid",   32'(dv[0]), 32'd0);
    adv();
    rst = 1'b0; uv[0] = 1'b0;
    smp();
    chk("rdy_before_edge", 32'(ur[0]), 32'd0);
    chk("no_bypass_before_ready", 32'(dv[0]), 32'd0);
    adv();
    smp();
    chk("rdy_after_edge", 32'(ur[0]), 32'd1);
    adv();

    // Bypass stream: zero latency, never stored.
    dr[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      uv[0] = 1'b1; ud[0] = 16'(i);
      smp();
      chk("byp_valid", 32'(dv[0]), 32'd1);
      chk("byp_data",  32'(dd[0]), 32'(i));
      chk("byp_level", 32'(lv0),   32'd0);
      adv();
    end
    uv[0] = 1'b0;

    // Fill against back-pressure: exactly DEPTH beats accepted.
    dr[0] = 1'b0; d = 16'd1;
    for (int c = 0; c < 6; c++) begin
      uv[0] = 1'b1; ud[0] = d;
      smp();
      if (fired[0]) d++;
      adv();
    end
    uv[0] = 1'b0;
    smp();
    chk("fill_count", 32'(d - 16'd1), 32'd4);
    chk("fill_level", 32'(lv0),       32'd4);
    chk("fill_ready", 32'(ur[0]),     32'd0);
    chk("fill_head",  32'(dd[0]),     32'h0001);
    adv();
    dr[0] = 1'b1;
    smp();
    adv();
    smp();
    chk("rdy_after_pop", 32'(ur[0]), 32'd1);
    chk("lvl_after_pop", 32'(lv0),   32'd3);
    adv();
    for (int n = 0; n < 10 && sbq[0].size() != 0; n++) begin
      smp();
      adv();
    end
    smp();
    chk("drain_empty", 32'(sbq[0].size()), 32'd0);
    chk("drain_level", 32'(lv0), 32'd0);
    adv();

    // Flush at level 3 with a simultaneous upstream handshake.
    dr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uv[0] = 1'b1; ud[0] = 16'h0100 + 16'(i);
      smp();
      adv();
    end
    uv[0] = 1'b1; ud[0] = 16'h01FF; fl[0] = 1'b1; dr[0] = 1'b1;
    smp();
    chk("flush_lvl3",      32'(lv0),   32'd3);
    chk("flush_up_accept", 32'(ur[0]), 32'd1);
    adv();
    fl[0] = 1'b0; uv[0] = 1'b0;
    smp();
    chk("post_flush_level", 32'(lv0),   32'd0);
    chk("post_flush_ready", 32'(ur[0]), 32'd1);
    chk("flush_beat_drop",  32'(dv[0]), 32'd0);
    adv();

    // Reset mid-stream at level 3.
    dr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uv[0] = 1'b1; ud[0] = 16'h0200 + 16'(i);
      smp();
      adv();
    end
    uv[0] = 1'b0;
    smp();
    chk("pre_rst_level", 32'(lv0), 32'd3);
    adv();
    rst = 1'b1;
    #1;
    chk("async_rst_level",  32'(lv0),   32'd0);
    chk("async_rst_dvalid", 32'(dv[0]), 32'd0);
    chk("async_rst_ready",  32'(ur[0]), 32'd0);
    smp();
    adv();
    rst = 1'b0; dr[0] = 1'b1;
    smp();
    chk("rel_ready_low", 32'(ur[0]), 32'd0);
    chk("rel_no_beat",   32'(dv[0]), 32'd0);
    adv();
    smp();
    chk("rel_ready_high",  32'(ur[0]), 32'd1);
    chk("rel_no_beat_2",   32'(dv[0]), 32'd0);
    adv();

    // Registered-output mode: one cycle of latency.
    dr[2] = 1'b1; uv[2] = 1'b1; ud[2] = 16'hABCD;
    smp();
    chk("regout_no_comb", 32'(dv[2]), 32'd0);
    adv();
    uv[2] = 1'b0;
    smp();
    chk("regout_valid", 32'(dv[2]), 32'd1);
    chk("regout_data",  32'(dd[2]), 32'hABCD);
    adv();
    smp();
    chk("regout_empty", 32'(dv[2]), 32'd0);
    adv();

    // Random traffic on all instances; upstream holds a beat until accepted.
    chk_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      uv[k] = 1'b0; seq[k] = 16'h1000 * 16'(k + 1);
    end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (fired[k]) seq[k]++;
        if (!uv[k] || fired[k]) begin
          uv[k] = 1'($urandom_range(0, 1));
          ud[k] = seq[k];
        end
        dr[k] = 1'($urandom_range(0, 1));
        fl[k] = ($urandom_range(0, 249) == 0);
      end
      smp();
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      uv[k] = 1'b0; dr[k] = 1'b1; fl[k] = 1'b0;
    end
    for (int n = 0; n < 8; n++) begin
      smp();
      adv();
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("final_empty[%0d]", k), 32'(sbq[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
